// File: rtl/line_word_bridge_if.sv
// Bus bundles for the line/word bridge.
// line_bus_if : cache-side line port (master = cache, slave = bridge).
// word_bus_if : memory-side word port (master = bridge, slave = memory).

interface line_bus_if #(
    parameter int BIT_W  = 32,
    parameter int ADDR_W = 32
);
    logic                 cen;
    logic                 wen;
    logic [ADDR_W-1:0]    addr;
    logic [4*BIT_W-1:0]   wdata;
    logic [4*BIT_W-1:0]   rdata;
    logic                 stall;

    modport master (output cen, wen, addr, wdata, input rdata, stall);
    modport slave  (input cen, wen, addr, wdata, output rdata, stall);
endinterface

interface word_bus_if #(
    parameter int BIT_W  = 32,
    parameter int ADDR_W = 32
);
    logic                 cen;
    logic                 wen;
    logic [ADDR_W-1:0]    addr;
    logic [BIT_W-1:0]     wdata;
    logic [BIT_W-1:0]     rdata;
    logic                 stall;

    modport master (output cen, wen, addr, wdata, input rdata, stall);
    modport slave  (input cen, wen, addr, wdata, output rdata, stall);
endinterface

// File: rtl/line_word_bridge.sv
// Splits 128-bit cache line transfers into four 32-bit word beats toward main
// memory, reassembles read beats into a line, and keeps saturating line counters.

module line_word_bridge #(
    parameter int BIT_W  = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    line_bus_if.slave        line,
    word_bus_if.master       word,
    output logic [CNT_W-1:0] o_rd_lines,
    output logic [CNT_W-1:0] o_wr_lines
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEAT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]             state;
    logic [1:0]             cnt;
    logic [ADDR_W-1:0]      base;
    logic                   wen_q;
    logic [3:0][BIT_W-1:0]  wdata_q;
    logic [3:0][BIT_W-1:0]  line_q;
    logic                   beat_done;
    logic                   unused_addr_lsbs;

    // Line address low nibble is a byte offset inside the line and is dropped.
    assign unused_addr_lsbs = ^line.addr[3:0];

    assign beat_done = (state == BEAT) && !word.stall;

    // Word-side outputs are pure decodes of registered state, so reset
    // removes the beat request immediately.
    assign word.cen   = (state == BEAT);
    assign word.wen   = (state == BEAT) && wen_q;
    assign word.addr  = base + {{(ADDR_W-4){1'b0}}, cnt, 2'b00};
    assign word.wdata = wdata_q[cnt];

    // Stall is released only in RESP; no path from the incoming request.
    assign line.stall = (state != RESP);
    assign line.rdata = line_q;

    // Request acceptance, beat sequencing and field latching.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            base    <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line.cen) begin
                        base    <= {line.addr[ADDR_W-1:4], 4'b0000};
                        wen_q   <= line.wen;
                        wdata_q <= line.wdata;
                        cnt     <= 2'd0;
                        state   <= BEAT;
                    end
                end
                BEAT: begin
                    if (!word.stall) begin
                        if (cnt == 2'd3) state <= RESP;
                        else             cnt   <= cnt + 2'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read beats land in their word slot; write lines never touch the buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_q <= '0;
        end else if (beat_done && !wen_q) begin
            line_q[cnt] <= word.rdata;
        end
    end

    // Completed-line counters, held at all-ones once full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_lines <= '0;
            o_wr_lines <= '0;
        end else if (state == RESP) begin
            if (wen_q) begin
                if (o_wr_lines != {CNT_W{1'b1}}) o_wr_lines <= o_wr_lines + 1'b1;
            end else begin
                if (o_rd_lines != {CNT_W{1'b1}}) o_rd_lines <= o_rd_lines + 1'b1;
            end
        end
    end

endmodule
